// File: rtl/cdb_result_buffer_pkg.sv
// Shared types for the common data bus (CDB) producer side.
// cdb_t is the payload an execution unit broadcasts on the CDB.
package cdb_result_buffer_pkg;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } cdb_t;

endpackage

// File: rtl/cdb_result_buffer.sv
// Per-execution-unit result FIFO feeding one CDB arbiter slot.
// It absorbs results while the arbiter grants other slots and presents the oldest entry as a request.
module cdb_result_buffer
    import cdb_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fu_valid,
    input  cdb_t             fu_data,
    output logic             fu_ready,
    output logic             cdb_req,
    output cdb_t             cdb_data,
    input  logic             cdb_grant,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    cdb_t             mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshakes: a push transfers on fu_valid && fu_ready, a pop on cdb_req && cdb_grant.
    // fu_ready looks only at the registered count, so a same-cycle grant never opens a slot.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign fu_ready  = !full;
    assign cdb_req   = !empty && !flush;
    assign cdb_data  = cdb_req ? mem[rd_ptr] : '0;
    assign push      = fu_valid && !full && !flush;
    assign pop       = cdb_req && cdb_grant;
    assign occupancy = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fu_data;
    end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Bench for cdb_result_buffer: directed sequences drive the unit/arbiter side, and a negedge
// monitor holds a reference model with an expected-data queue that every presented entry is checked against.
module tb_cdb_result_buffer;
    import cdb_result_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = $bits(cdb_t);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             fu_valid;
    cdb_t             fu_data;
    logic             fu_ready;
    logic             cdb_req;
    cdb_t             cdb_data;
    logic             cdb_grant;
    logic [CNT_W-1:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    int           model_count = 0;
    logic         prev_req    = 1'b0;
    logic         prev_grant  = 1'b0;
    cdb_t         prev_data   = '0;
    int           dut_pushes  = 0;
    int           dut_pops    = 0;

    cdb_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .cdb_req   (cdb_req),
        .cdb_data  (cdb_data),
        .cdb_grant (cdb_grant),
        .occupancy (occupancy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Payload for tag letter n (A=1, B=2, ...).
    function automatic cdb_t pl(input int n);
        cdb_t p;
        p.tag   = 6'(n);
        p.value = 32'hC0DE_0000 + 32'(n);
        return p;
    endfunction

    task automatic step(input logic v, input cdb_t d, input logic g, input logic f);
        fu_valid  = v;
        fu_data   = d;
        cdb_grant = g;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard: inputs are stable at negedge and equal to what the next edge will see.
    always @(negedge clk) begin
        logic exp_req;
        logic do_push;
        if (rst) begin
            chk("rst_req", 64'(cdb_req), 64'd0);
            chk("rst_ready", 64'(fu_ready), 64'd1);
            chk("rst_occ", 64'(occupancy), 64'd0);
            chk("rst_data", 64'(cdb_data), 64'd0);
            exp_q.delete();
            model_count = 0;
            prev_req    = 1'b0;
        end else begin
            exp_req = (model_count != 0) && !flush;
            chk("fu_ready", 64'(fu_ready), 64'(model_count != DEPTH));
            chk("occupancy", 64'(occupancy), 64'(model_count));
            chk("cdb_req", 64'(cdb_req), 64'(exp_req));
            if (exp_req) chk("cdb_data", 64'(cdb_data), 64'(exp_q[0]));
            else         chk("idle_data", 64'(cdb_data), 64'd0);
            if (prev_req && !prev_grant && !flush) begin
                chk("hold_req", 64'(cdb_req), 64'd1);
                chk("hold_data", 64'(cdb_data), 64'(prev_data));
            end
            if (occupancy == CNT_W'(DEPTH)) chk("full_no_push", 64'(fu_ready), 64'd0);
            if (fu_valid && fu_ready && !flush) dut_pushes++;
            if (cdb_req && cdb_grant) dut_pops++;
            chk("pops_le_pushes", 64'(dut_pops <= dut_pushes), 64'd1);

            do_push = fu_valid && (model_count != DEPTH);
            if (flush) begin
                exp_q.delete();
                model_count = 0;
            end else begin
                if (exp_req && cdb_grant) begin
                    void'(exp_q.pop_front());
                    model_count--;
                end
                if (do_push) begin
                    exp_q.push_back(W'(fu_data));
                    model_count++;
                end
            end
            prev_req   = cdb_req;
            prev_grant = cdb_grant;
            prev_data  = cdb_data;
        end
    end

    // Directed stimulus
    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        fu_valid  = 1'b0;
        fu_data   = '0;
        cdb_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: idle after reset, then a single push with grant held high
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t1_req", 64'(cdb_req), 64'd0);
        chk("t1_ready", 64'(fu_ready), 64'd1);
        chk("t1_occ", 64'(occupancy), 64'd0);
        step(1'b1, pl(1), 1'b1, 1'b0);
        chk("t1_req_next", 64'(cdb_req), 64'd1);
        chk("t1_data_next", 64'(cdb_data), 64'(pl(1)));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t1_occ_after", 64'(occupancy), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);

        // 2: fill with grant low, E is refused, then drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, pl(i), 1'b0, 1'b0);
        chk("t2_occ_full", 64'(occupancy), 64'd4);
        chk("t2_ready_full", 64'(fu_ready), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_req_empty", 64'(cdb_req), 64'd0);
        chk("t2_occ_empty", 64'(occupancy), 64'd0);

        // 3: full buffer, push and grant together
        for (int i = 1; i <= 4; i++) step(1'b1, pl(i), 1'b0, 1'b0);
        step(1'b1, pl(5), 1'b1, 1'b0);
        chk("t3_occ_after_pop", 64'(occupancy), 64'd3);
        chk("t3_ready", 64'(fu_ready), 64'd1);
        step(1'b1, pl(5), 1'b0, 1'b0);
        chk("t3_occ_refill", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t3_occ_drained", 64'(occupancy), 64'd0);

        // 4: steady state at occupancy 2 across pointer wrap
        step(1'b1, pl(1), 1'b0, 1'b0);
        step(1'b1, pl(2), 1'b0, 1'b0);
        for (int i = 3; i <= 12; i++) begin
            step(1'b1, pl(i), 1'b1, 1'b0);
            chk("t4_occ_steady", 64'(occupancy), 64'd2);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t4_occ_drained", 64'(occupancy), 64'd0);

        // 5: flush at occupancy 3 with a push and grant offered
        for (int i = 1; i <= 3; i++) step(1'b1, pl(i), 1'b0, 1'b0);
        fu_valid  = 1'b1;
        fu_data   = pl(9);
        cdb_grant = 1'b1;
        flush     = 1'b1;
        #1;
        chk("t5_req_in_flush", 64'(cdb_req), 64'd0);
        @(posedge clk);
        #1;
        fu_valid  = 1'b0;
        flush     = 1'b0;
        #1;
        chk("t5_occ_after", 64'(occupancy), 64'd0);
        chk("t5_req_after", 64'(cdb_req), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 6: asynchronous reset mid-stream at occupancy 2
        step(1'b1, pl(1), 1'b0, 1'b0);
        step(1'b1, pl(2), 1'b0, 1'b0);
        fu_valid = 1'b0;
        chk("t6_occ_before", 64'(occupancy), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_async", 64'(cdb_req), 64'd0);
        chk("t6_occ_async", 64'(occupancy), 64'd0);
        chk("t6_ready_async", 64'(fu_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, pl(7), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
